// File: rtl/traffic_ctrl_multi_if.sv
// Purpose : bundles the controller's sensor, timebase and lamp signals into one port.
// Latency : none, wires only.
// Backpressure: none; every signal is sampled or presented each cycle.
//
// Ports:
//   tick       timebase enable
//   car_req    per-approach vehicle sensors
//   force_red  emergency all-red request
//   lamps      {G,Y,R} per approach
//   active_dir approach owning, or last owning, green
//   phase      0=GREEN 1=YELLOW 2=ALL_RED 3=WALK
//   ped_req    pedestrian request (PED_WALK_EN only)
//   walk       walk indication (PED_WALK_EN only)
//
// Modports:
//   slave  is the controller side.
//   master is the environment side.
interface traffic_ctrl_multi_if #(
    parameter int NUM_DIR = 4
);
    localparam int DIR_W = $clog2(NUM_DIR);

    logic                 tick;
    logic [NUM_DIR-1:0]   car_req;
    logic                 force_red;
    logic [3*NUM_DIR-1:0] lamps;
    logic [DIR_W-1:0]     active_dir;
    logic [1:0]           phase;
`ifdef PED_WALK_EN
    logic                 ped_req;
    logic                 walk;
`endif

`ifdef PED_WALK_EN
    modport slave  (input  tick, car_req, force_red, ped_req,
                    output lamps, active_dir, phase, walk);
    modport master (output tick, car_req, force_red, ped_req,
                    input  lamps, active_dir, phase, walk);
`else
    modport slave  (input  tick, car_req, force_red,
                    output lamps, active_dir, phase);
    modport master (output tick, car_req, force_red,
                    input  lamps, active_dir, phase);
`endif
endinterface

// File: rtl/traffic_ctrl_multi.sv
// Purpose : round-robin, sensor-actuated GREEN/YELLOW/ALL_RED light controller for NUM_DIR approaches.
// Latency : outputs are decoded from registered state, one clock after the deciding edge.
// Backpressure: none; requests are latched until served, and force_red holds all-red.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  traffic_ctrl_multi_if.slave, carrying tick, car_req, force_red, lamps,
//        active_dir and phase (plus ped_req and walk when PED_WALK_EN is defined)
//
// Optional feature: define PED_WALK_EN to add the pedestrian WALK phase.
module traffic_ctrl_multi #(
    parameter int NUM_DIR      = 4,
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 10
) (
    input logic                  clk,
    input logic                  rst,
    traffic_ctrl_multi_if.slave  bus
);
    localparam int DIR_W = $clog2(NUM_DIR);

    localparam logic [1:0] S_GREEN  = 2'd0;
    localparam logic [1:0] S_YELLOW = 2'd1;
    localparam logic [1:0] S_ALLRED = 2'd2;
`ifdef PED_WALK_EN
    localparam logic [1:0] S_WALK   = 2'd3;
`endif

    logic [1:0]           state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [NUM_DIR-1:0]   pending, pending_nxt, clr;
    logic [DIR_W-1:0]     active_dir, dir_nxt;
    logic                 reload;
    logic                 expire;
    logic                 others;
    logic                 found;
    logic [DIR_W-1:0]     rr_sel;
    logic [2*NUM_DIR-1:0] pend2;
    logic [2*NUM_DIR-1:0] rot;
    logic [NUM_DIR-1:0]   rot_lo;
    logic [DIR_W:0]       sh;
    logic [DIR_W:0]       off;
    logic [DIR_W:0]       sum;
    logic [3*NUM_DIR-1:0] lamps_d;
`ifdef PED_WALK_EN
    logic                 pending_ped;
    logic                 ped_clr;
`endif

    assign expire = bus.tick && (cnt == '0);

    // Green may only be given away if someone other than the owner is waiting.
    always_comb begin
        others = |(pending & ~(NUM_DIR'(1) << active_dir));
`ifdef PED_WALK_EN
        others = others | pending_ped;
`endif
    end

    // Round-robin search: rotate the pending vector so that bit 0 is the
    // approach after active_dir, take the lowest set bit, then map back.
    // The owner itself is considered last.
    always_comb begin
        pend2  = {pending, pending};
        sh     = {1'b0, active_dir} + (DIR_W+1)'(1);
        rot    = pend2 >> sh;
        rot_lo = rot[NUM_DIR-1:0];
        found  = 1'b0;
        off    = '0;
        for (int k = NUM_DIR - 1; k >= 0; k--) begin
            if (rot_lo[k]) begin
                found = 1'b1;
                off   = (DIR_W+1)'(k);
            end
        end
        sum = sh + off;
        if (sum >= (DIR_W+1)'(NUM_DIR)) begin
            sum = sum - (DIR_W+1)'(NUM_DIR);
        end
        rr_sel = sum[DIR_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = active_dir;
        clr       = '0;
        reload    = 1'b0;
`ifdef PED_WALK_EN
        ped_clr   = 1'b0;
`endif
        case (state)
            S_GREEN: begin
                if (bus.force_red) begin
                    state_nxt = S_YELLOW;
                    reload    = 1'b1;
                end else if (expire) begin
                    // Without other demand, rest in green by restarting the phase.
                    if (others) state_nxt = S_YELLOW;
                    reload = 1'b1;
                end
            end
            S_YELLOW: begin
                if (expire) begin
                    state_nxt = S_ALLRED;
                    reload    = 1'b1;
                end
            end
            S_ALLRED: begin
                if (expire) begin
                    reload = 1'b1;
                    if (!bus.force_red) begin
                        if (found) begin
                            state_nxt = S_GREEN;
                            dir_nxt   = rr_sel;
                            clr       = NUM_DIR'(1) << rr_sel;
                        end
`ifdef PED_WALK_EN
                        // Pedestrians win over vehicles; ownership is kept.
                        if (pending_ped) begin
                            state_nxt = S_WALK;
                            dir_nxt   = active_dir;
                            clr       = '0;
                            ped_clr   = 1'b1;
                        end
`endif
                    end
                end
            end
`ifdef PED_WALK_EN
            S_WALK: begin
                if (bus.force_red || expire) begin
                    state_nxt = S_ALLRED;
                    reload    = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = S_ALLRED;
                reload    = 1'b1;
            end
        endcase

        if (reload) begin
            case (state_nxt)
                S_GREEN:  cnt_nxt = CNT_W'(GREEN_TICKS - 1);
                S_YELLOW: cnt_nxt = CNT_W'(YELLOW_TICKS - 1);
                S_ALLRED: cnt_nxt = CNT_W'(ALLRED_TICKS - 1);
                default:  cnt_nxt = CNT_W'(WALK_TICKS - 1);
            endcase
        end else if (bus.tick && cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
        end else begin
            cnt_nxt = cnt;
        end

        // A clear wins over a simultaneous new request.
        pending_nxt = (pending | bus.car_req) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_ALLRED;
            cnt         <= CNT_W'(ALLRED_TICKS - 1);
            pending     <= '0;
            active_dir  <= DIR_W'(NUM_DIR - 1);
`ifdef PED_WALK_EN
            pending_ped <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pending     <= pending_nxt;
            active_dir  <= dir_nxt;
`ifdef PED_WALK_EN
            pending_ped <= (pending_ped | bus.ped_req) & ~ped_clr;
`endif
        end
    end

    always_comb begin
        lamps_d = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            lamps_d[3*i +: 3] = 3'b001;
            if (DIR_W'(i) == active_dir) begin
                if (state == S_GREEN)  lamps_d[3*i +: 3] = 3'b100;
                if (state == S_YELLOW) lamps_d[3*i +: 3] = 3'b010;
            end
        end
    end

    assign bus.lamps      = lamps_d;
    assign bus.active_dir = active_dir;
    assign bus.phase      = state;
`ifdef PED_WALK_EN
    assign bus.walk       = (state == S_WALK);
`endif
endmodule

// File: tb/tb_traffic_ctrl_multi.sv
module tb_traffic_ctrl_multi;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    traffic_ctrl_multi_if #(.NUM_DIR(N)) bus();

    traffic_ctrl_multi #(
        .NUM_DIR(N), .CNT_W(8), .GREEN_TICKS(20), .YELLOW_TICKS(4),
        .ALLRED_TICKS(2), .WALK_TICKS(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_period = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases are timed by counting elapsed ticks upward against a duration table.
    int       m_phase;
    int       m_done;
    int       m_dir;
    bit [N-1:0] m_pend;
    bit       m_pped;
    bit       m_valid = 1'b0;

    function automatic int dur(input int p);
        case (p)
            0: return 20;
            1: return 4;
            2: return 2;
            default: return 10;
        endcase
    endfunction

    function automatic logic [3*N-1:0] exp_lamps(input int p, input int d);
        logic [3*N-1:0] v;
        for (int i = 0; i < N; i++) begin
            if (i == d && p == 0)      v[3*i +: 3] = 3'b100;
            else if (i == d && p == 1) v[3*i +: 3] = 3'b010;
            else                       v[3*i +: 3] = 3'b001;
        end
        return v;
    endfunction

    always @(posedge clk) begin : model
        bit expd, restart, others, found, pclr, frc, tk, preq;
        int nph, idx, sel;
        bit [N-1:0] clr;
        if (rst) begin
            m_phase = 2; m_done = 0; m_dir = N - 1; m_pend = '0; m_pped = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            tk = bus.tick; frc = bus.force_red;
            preq = 1'b0;
`ifdef PED_WALK_EN
            preq = bus.ped_req;
`endif
            expd = tk && (m_done == dur(m_phase) - 1);
            nph = m_phase; restart = 1'b0; clr = '0; pclr = 1'b0;
            others = m_pped;
            for (int i = 0; i < N; i++) if (i != m_dir && m_pend[i]) others = 1'b1;
            case (m_phase)
                0: if (frc) nph = 1;
                   else if (expd) begin if (others) nph = 1; else restart = 1'b1; end
                1: if (expd) nph = 2;
                2: if (expd) begin
                       if (frc) restart = 1'b1;
                       else if (m_pped) begin nph = 3; pclr = 1'b1; end
                       else begin
                           found = 1'b0; sel = 0;
                           for (int k = 1; k <= N; k++) begin
                               idx = (m_dir + k) % N;
                               if (!found && m_pend[idx]) begin found = 1'b1; sel = idx; end
                           end
                           if (found) begin nph = 0; m_dir = sel; clr[sel] = 1'b1; end
                           else restart = 1'b1;
                       end
                   end
                default: if (frc || expd) nph = 2;
            endcase
            if (nph != m_phase || restart) m_done = 0;
            else if (tk) m_done = m_done + 1;
            m_pend  = (m_pend | bus.car_req) & ~clr;
            m_pped  = (m_pped | preq) & ~pclr;
            m_phase = nph;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("lamps", 32'(bus.lamps), 32'(exp_lamps(m_phase, m_dir)));
            chk("phase", 32'(bus.phase), 32'(m_phase));
            chk("active_dir", 32'(bus.active_dir), 32'(m_dir));
`ifdef PED_WALK_EN
            chk("walk", 32'(bus.walk), 32'(m_phase == 3));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        bus.tick = ((cyc % tick_period) == 0);
    endtask

    task automatic wait_for(input string name, input int p, input int d, input int budget);
        int n;
        n = 0;
        while (!(int'(bus.phase) == p && (d < 0 || int'(bus.active_dir) == d)) && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    task automatic count_phase(input int p, output int n);
        n = 0;
        while (int'(bus.phase) == p && n < 1000) begin
            step();
            n++;
        end
    endtask

    int n;
    int bad;

    initial begin
        rst = 1'b1;
        bus.tick = 1'b1;
        bus.car_req = '0;
        bus.force_red = 1'b0;
`ifdef PED_WALK_EN
        bus.ped_req = 1'b0;
`endif
        repeat (3) step();
        rst = 1'b0;

        // Reset state and idle all-red
        chk("rst_lamps", 32'(bus.lamps), 32'h249);
        chk("rst_phase", 32'(bus.phase), 32'd2);
        chk("rst_dir", 32'(bus.active_dir), 32'd3);
        repeat (12) step();
        chk("idle_lamps", 32'(bus.lamps), 32'h249);
        chk("idle_phase", 32'(bus.phase), 32'd2);

        // One-cycle request on approach 2, then rest in green
        bus.car_req = 4'b0100; step(); bus.car_req = '0;
        wait_for("to_green2", 0, 2, 10);
        chk("green2_lamps", 32'(bus.lamps), 32'h309);
        repeat (30) step();
        chk("rest_green2", 32'(bus.lamps), 32'h309);

        // Move to approach 0
        bus.car_req = 4'b0001; step(); bus.car_req = '0;
        wait_for("to_green0", 0, 0, 60);
        chk("green0_lamps", 32'(bus.lamps), 32'h24c);
        repeat (5) step();

        // Requests on 1 and 3 while 0 rests in green
        bus.car_req = 4'b1010; step(); bus.car_req = '0;
        wait_for("to_yellow0", 1, 0, 40);
        chk("yellow0_lamps", 32'(bus.lamps), 32'h24a);
        count_phase(1, n); chk("yellow_len", 32'(n), 32'd4);
        count_phase(2, n); chk("allred_len", 32'(n), 32'd2);
        chk("served1_phase", 32'(bus.phase), 32'd0);
        chk("served1_dir", 32'(bus.active_dir), 32'd1);
        count_phase(0, n); chk("green1_len", 32'(n), 32'd20);
        count_phase(1, n); chk("yellow1_len", 32'(n), 32'd4);
        count_phase(2, n); chk("allred1_len", 32'(n), 32'd2);
        chk("served3_dir", 32'(bus.active_dir), 32'd3);

        // force_red mid-green
        repeat (10) step();
        bus.force_red = 1'b1;
        step();
        chk("force_yellow", 32'(bus.phase), 32'd1);
        count_phase(1, n); chk("force_yellow_len", 32'(n), 32'd4);
        bad = 0;
        bus.car_req = 4'b0001;
        for (int i = 0; i < 15; i++) begin
            if (int'(bus.phase) != 2) bad++;
            step();
            bus.car_req = '0;
        end
        chk("force_hold", 32'(bad), 32'd0);
        bus.force_red = 1'b0;
        wait_for("after_release", 0, 0, 10);

        // Slow timebase: one tick every 5 clocks
        tick_period = 5;
        bus.car_req = 4'b0100; step(); bus.car_req = '0;
        wait_for("slow_to_yellow", 1, 0, 200);
        count_phase(1, n); chk("slow_yellow_len", 32'(n), 32'd20);
        count_phase(2, n); chk("slow_allred_len", 32'(n), 32'd10);
        chk("slow_dir", 32'(bus.active_dir), 32'd2);
        tick_period = 1;

`ifdef PED_WALK_EN
        bus.ped_req = 1'b1; bus.car_req = 4'b0010; step();
        bus.ped_req = 1'b0; bus.car_req = '0;
        wait_for("to_walk", 3, 2, 100);
        chk("walk_lamps", 32'(bus.lamps), 32'h249);
        chk("walk_on", 32'(bus.walk), 32'd1);
        count_phase(3, n); chk("walk_len", 32'(n), 32'd10);
        count_phase(2, n); chk("walk_allred_len", 32'(n), 32'd2);
        chk("after_walk_dir", 32'(bus.active_dir), 32'd1);
        chk("after_walk_phase", 32'(bus.phase), 32'd0);
`endif

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
